// File: rtl/core_pkg.sv
// Shared types and helpers for the D-stage branch forwarding/hazard unit.
package core_pkg;

    // Architectural register address width; x0 never forwards.
    localparam int REG_AW = 5;

    // Width of a forward-select code: 0 = regfile, k+1 = tracker slot k.
    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One in-flight downstream instruction as seen by the tracker.
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              wren;
        logic              is_load;
    } fwd_slot_t;

    localparam fwd_slot_t SLOT_EMPTY = '{
        vld:     1'b0,
        rd:      {REG_AW{1'b0}},
        wren:    1'b0,
        is_load: 1'b0
    };

endpackage

// File: rtl/br_fwd_hazard_unit_src_match.sv
// Per-operand producer match: picks the youngest tracker slot writing the
// operand's register and decides whether its data can be forwarded yet.
module fwd_src_match
    import core_pkg::*;
#(
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1,
    parameter int SELW      = 2
) (
    input  fwd_slot_t [FWD_DEPTH-1:0] i_slots,
    input  logic [REG_AW-1:0]         i_rs_addr,
    input  logic                      i_rs_used,
    input  logic                      i_valid,
    output logic [SELW-1:0]           o_fwd_sel,
    output logic                      o_stall
);

    logic [FWD_DEPTH-1:0] hit_s;
    logic                 hit_any_s;
    logic [SELW-1:0]      win_idx_s;
    logic                 win_load_s;
    logic                 win_ready_s;

    // Per-slot hit: a live writer of a non-zero register that D really reads.
    always_comb begin
        hit_s = {FWD_DEPTH{1'b0}};
        for (int k = 0; k < FWD_DEPTH; k++) begin
            hit_s[k] = i_slots[k].vld & i_slots[k].wren
                     & (i_slots[k].rd == i_rs_addr)
                     & (i_rs_addr != {REG_AW{1'b0}})
                     & i_rs_used & i_valid;
        end
    end

    // Scan oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        hit_any_s  = 1'b0;
        win_idx_s  = {SELW{1'b0}};
        win_load_s = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            hit_any_s  = hit_s[k] ? 1'b1              : hit_any_s;
            win_idx_s  = hit_s[k] ? SELW'(k)          : win_idx_s;
            win_load_s = hit_s[k] ? i_slots[k].is_load : win_load_s;
        end
        // Load data only exists from LOAD_LAT onwards; ALU results are always ready.
        win_ready_s = ~win_load_s | (win_idx_s >= SELW'(LOAD_LAT));
    end

    // Forward from the winner when ready, otherwise request a stall.
    always_comb begin
        if (hit_any_s && win_ready_s) begin
            o_fwd_sel = win_idx_s + SELW'(1);
            o_stall   = 1'b0;
        end else if (hit_any_s) begin
            o_fwd_sel = {SELW{1'b0}};
            o_stall   = 1'b1;
        end else begin
            o_fwd_sel = {SELW{1'b0}};
            o_stall   = 1'b0;
        end
    end

endmodule

// File: rtl/br_fwd_hazard_unit.sv
// D-stage forwarding/hazard unit for branch operand comparison: tracks
// downstream destination writes, selects forward sources per operand,
// stalls on not-yet-ready load data and counts stall cycles.
module br_fwd_hazard_unit
    import core_pkg::*;
#(
    parameter  int NUM_SRC   = 2,
    parameter  int FWD_DEPTH = 3,
    parameter  int LOAD_LAT  = 1,
    parameter  int CNT_W     = 16,
    localparam int SELW      = fwd_sel_w(FWD_DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_SRC*REG_AW-1:0] i_rs_addr_D,
    input  logic [NUM_SRC-1:0]        i_rs_used_D,
    input  logic                      i_valid_D,
    input  logic [REG_AW-1:0]         i_rd_addr_D,
    input  logic                      i_rd_wren_D,
    input  logic                      i_is_load_D,
    input  logic                      i_flush,
    input  logic                      i_hold,
    output logic [NUM_SRC*SELW-1:0]   o_fwd_sel,
    output logic                      o_stall_D,
    output logic [CNT_W-1:0]          o_stall_cnt
);

    // A load could never become forwardable inside the tracker.
    if (LOAD_LAT >= FWD_DEPTH) begin : g_bad_load_lat
        $error("br_fwd_hazard_unit: LOAD_LAT must be smaller than FWD_DEPTH");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    fwd_slot_t [FWD_DEPTH-1:0] slot_q;
    fwd_slot_t [FWD_DEPTH-1:0] slot_d;
    fwd_slot_t [FWD_DEPTH-1:0] slot_view_s;
    logic [CNT_W-1:0]          stall_cnt_q;
    logic [CNT_W-1:0]          stall_cnt_d;
    logic [NUM_SRC-1:0]        stall_vec_s;
    logic                      stall_s;

    // While reset is asserted the decision logic already sees an empty tracker.
    always_comb begin
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (i_reset) begin
                slot_view_s[k] = SLOT_EMPTY;
            end else begin
                slot_view_s[k] = slot_q[k];
            end
        end
    end

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        fwd_src_match #(
            .FWD_DEPTH (FWD_DEPTH),
            .LOAD_LAT  (LOAD_LAT),
            .SELW      (SELW)
        ) u_match (
            .i_slots   (slot_view_s),
            .i_rs_addr (i_rs_addr_D[n*REG_AW +: REG_AW]),
            .i_rs_used (i_rs_used_D[n]),
            .i_valid   (i_valid_D),
            .o_fwd_sel (o_fwd_sel[n*SELW +: SELW]),
            .o_stall   (stall_vec_s[n])
        );
    end

    assign stall_s     = |stall_vec_s;
    assign o_stall_D   = stall_s;
    assign o_stall_cnt = stall_cnt_q;

    // Next tracker/counter state: shift unless frozen; stall or flush enters a bubble.
    always_comb begin
        slot_d      = slot_q;
        stall_cnt_d = stall_cnt_q;
        if (i_hold) begin
            slot_d      = slot_q;
            stall_cnt_d = stall_cnt_q;
        end else begin
            for (int k = 1; k < FWD_DEPTH; k++) begin
                slot_d[k] = slot_q[k-1];
            end
            slot_d[0] = '{
                vld:     i_valid_D & ~i_flush & ~stall_s,
                rd:      i_rd_addr_D,
                wren:    i_rd_wren_D,
                is_load: i_is_load_D
            };
            if (stall_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    // State registers with synchronous reset to an empty tracker and zero count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                slot_q[k] <= SLOT_EMPTY;
            end
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_br_fwd_hazard_unit.sv
// Scoreboard bench for br_fwd_hazard_unit (defaults, CNT_W reduced to 4).
// The driver applies one D-stage vector per cycle and queues the expected
// outputs; the monitor compares them on the falling edge.
module tb_br_fwd_hazard_unit;

    logic        clk;
    logic        i_reset;
    logic [9:0]  i_rs_addr_D;
    logic [1:0]  i_rs_used_D;
    logic        i_valid_D;
    logic [4:0]  i_rd_addr_D;
    logic        i_rd_wren_D;
    logic        i_is_load_D;
    logic        i_flush;
    logic        i_hold;
    logic [3:0]  o_fwd_sel;
    logic        o_stall_D;
    logic [3:0]  o_stall_cnt;

    typedef struct {
        string      nm;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       st;
        logic [3:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    br_fwd_hazard_unit #(
        .NUM_SRC   (2),
        .FWD_DEPTH (3),
        .LOAD_LAT  (1),
        .CNT_W     (4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_rs_addr_D (i_rs_addr_D),
        .i_rs_used_D (i_rs_used_D),
        .i_valid_D   (i_valid_D),
        .i_rd_addr_D (i_rd_addr_D),
        .i_rd_wren_D (i_rd_wren_D),
        .i_is_load_D (i_is_load_D),
        .i_flush     (i_flush),
        .i_hold      (i_hold),
        .o_fwd_sel   (o_fwd_sel),
        .o_stall_D   (o_stall_D),
        .o_stall_cnt (o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    // One cycle of stimulus plus the outputs required during that cycle.
    task automatic cyc(input string nm, input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [1:0] used,
                       input logic [4:0] rd, input logic wren, input logic ld,
                       input logic fl, input logic hd, input logic rst,
                       input logic [1:0] e1, input logic [1:0] e2,
                       input logic es, input logic [3:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid_D   = v;
        i_rs_addr_D = {rs2, rs1};
        i_rs_used_D = used;
        i_rd_addr_D = rd;
        i_rd_wren_D = wren;
        i_is_load_D = ld;
        i_flush     = fl;
        i_hold      = hd;
        i_reset     = rst;
        e.nm = nm; e.s1 = e1; e.s2 = e2; e.st = es; e.c = ec;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (o_fwd_sel[1:0] === e.s1 && o_fwd_sel[3:2] === e.s2 &&
                o_stall_D === e.st && o_stall_cnt === e.c) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got sel1=%0d sel2=%0d stall=%0b cnt=%0d, required sel1=%0d sel2=%0d stall=%0b cnt=%0d",
                         e.nm, o_fwd_sel[1:0], o_fwd_sel[3:2], o_stall_D, o_stall_cnt,
                         e.s1, e.s2, e.st, e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset = 1'b1; i_valid_D = 1'b0; i_rs_addr_D = '0; i_rs_used_D = '0;
        i_rd_addr_D = '0; i_rd_wren_D = 1'b0; i_is_load_D = 1'b0;
        i_flush = 1'b0; i_hold = 1'b0;

        //   name                 v  rs1 rs2 used  rd wr ld fl hd rst  sel1 sel2 st cnt
        cyc("reset",              0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 4'd0);
        cyc("alu_setup",          1,  0,  0, 2'b00, 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0);
        cyc("alu_fwd_E",          1,  5,  6, 2'b11, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 4'd0);
        cyc("load_setup",         1,  0,  0, 2'b00, 7, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0);
        cyc("load_use_stall",     1,  0,  7, 2'b10, 8, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1, 4'd0);
        cyc("load_use_M",         1,  8,  7, 2'b11, 8, 1, 0, 0, 0, 0, 2'd0, 2'd2, 0, 4'd1);
        cyc("yw_setup_a",         1,  0,  0, 2'b00, 3, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd1);
        cyc("yw_setup_b",         1,  0,  0, 2'b00, 3, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd1);
        cyc("yw_two_hits",        1,  3,  0, 2'b01, 3, 1, 0, 0, 0, 0, 2'd1, 2'd0, 0, 4'd1);
        cyc("youngest_wins",      1,  3,  0, 2'b01, 3, 1, 0, 1, 0, 0, 2'd1, 2'd0, 0, 4'd1);
        cyc("youngest_after_inv", 1,  3,  0, 2'b01, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 4'd1);
        cyc("x0_setup",           1,  0,  0, 2'b00, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd1);
        cyc("x0_no_fwd",          1,  0,  0, 2'b01, 4, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 4'd1);
        cyc("unused_rs2",         1,  0,  4, 2'b01, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd1);
        cyc("hold_setup",         1,  0,  0, 2'b00,10, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 4'd1);
        cyc("hold_1",             1, 10,  0, 2'b01,11, 1, 0, 0, 1, 0, 2'd0, 2'd0, 1, 4'd1);
        cyc("hold_2",             1, 10,  0, 2'b01,11, 1, 0, 0, 1, 0, 2'd0, 2'd0, 1, 4'd1);
        cyc("hold_3",             1, 10,  0, 2'b01,11, 1, 0, 0, 1, 0, 2'd0, 2'd0, 1, 4'd1);
        cyc("hold_release",       1, 10,  0, 2'b01,11, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1, 4'd1);
        cyc("after_hold",         1, 10,  0, 2'b01,11, 1, 0, 0, 0, 0, 2'd2, 2'd0, 0, 4'd2);
        cyc("flush_setup",        1,  0,  0, 2'b00,12, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 4'd2);
        cyc("flush_stall",        1, 12,  0, 2'b01,13, 1, 0, 1, 0, 0, 2'd0, 2'd0, 1, 4'd2);
        cyc("flush_after",        1, 13, 12, 2'b11, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 0, 4'd3);
        cyc("rst_setup",          1,  0,  0, 2'b00,14, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 4'd3);
        cyc("reset_mid_stall",    1, 14,  0, 2'b01,14, 1, 1, 0, 0, 1, 2'd0, 2'd0, 0, 4'd3);
        cyc("after_reset",        1, 14,  0, 2'b01,14, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            cyc("sat_stall",      1, 14,  0, 2'b01,14, 1, 1, 0, 0, 0, 2'd0, 2'd0, 1, sat4(i));
            cyc("sat_go",         1, 14,  0, 2'b01,14, 1, 1, 0, 0, 0, 2'd2, 2'd0, 0, sat4(i + 1));
        end
        cyc("sat_final",          0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd15);
        cyc("final_reset",        1, 14,  0, 2'b01, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 4'd15);
        cyc("post_reset",         1, 14,  0, 2'b01, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0);

        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
